ber_test_controller: RTL

BER_TEST_CONTROLLER -- requirements
Module: ber_test_controller

---
 rtl/ber_test_controller_if.sv | 37 +++
 rtl/ber_test_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ber_test_controller_if.sv
// ber_test_controller_if
//   Bundles the link and status signals of the BER test controller.
//   master : the controller (drives tx_bit, inj_stop and status)
//   slave  : the link / injector / host side
// Signals:
//   start      host request to begin a test
//   tx_bit     PRBS7 transmit bit to the link
//   rx_bit     received bit returned from the link
//   inj_stop   stop input of the error injector
//   inj_errors cumulative injected-error count from the injector (64 bit)
//   busy       test in progress (SYNC, RUN, DRAIN)
//   done       test finished (DONE)
//   pass       result, valid while done
//   err_count  mismatches counted since RUN entry (64 bit)
//   lock_fail  SYNC timed out
interface ber_test_controller_if;
    logic        start;
    logic        tx_bit;
    logic        rx_bit;
    logic        inj_stop;
    logic [63:0] inj_errors;
    logic        busy;
    logic        done;
    logic        pass;
    logic [63:0] err_count;
    logic        lock_fail;

    modport master (
        input  start, rx_bit, inj_errors,
        output tx_bit, inj_stop, busy, done, pass, err_count, lock_fail
    );

    modport slave (
        output start, rx_bit, inj_errors,
        input  tx_bit, inj_stop, busy, done, pass, err_count, lock_fail
    );
endinterface

// File: rtl/ber_test_controller.sv
// ber_test_controller
//   PRBS7 bit-error-rate test controller. Transmits a free-running PRBS7
//   stream, locks a checker onto the returned stream, counts bit errors over
//   a fixed measurement window with the injector enabled, drains the link,
//   and compares the measured count with the injector's own count.
// Ports:
//   clock  rising-edge clock, one bit per cycle
//   reset  synchronous, active-high
//   bus    ber_test_controller_if.master (start, tx_bit, rx_bit, inj_stop,
//          inj_errors, busy, done, pass, err_count, lock_fail)
// Configuration:
//   BER_TEST_LOCK_TIMEOUT_EN  when defined, SYNC gives up after LOCK_TIMEOUT
//                             cycles and reports lock_fail; otherwise SYNC
//                             waits indefinitely and lock_fail is tied 0.
module ber_test_controller #(
    parameter int unsigned LOCK_CYCLES  = 16,
    parameter int unsigned RUN_CYCLES   = 1000,
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    ber_test_controller_if.master        bus
);
    localparam int unsigned MW = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned RW = (RUN_CYCLES   > 1) ? $clog2(RUN_CYCLES)   : 1;
    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [6:0]    r_lfsr;
    logic [6:0]    r_chk;
    logic [MW-1:0] r_match;
    logic [RW-1:0] r_run;
    logic [DW-1:0] r_drain;
    logic [63:0]   r_err;
    logic [63:0]   r_inj_base;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic          r_inj_stop;

    logic          w_pred;
    logic          w_miss;
    logic          w_match_ok;
    logic          w_lock;
    logic [63:0]   w_err_next;

    assign w_pred = r_chk[6] ^ r_chk[5];
    assign w_miss = (bus.rx_bit != w_pred);
    // An all-zero checker is the PRBS lock-up state: it predicts 0 forever,
    // so a dead (stuck-at-0) link must not be mistaken for lock.
    assign w_match_ok = !w_miss && (r_chk != '0);
    assign w_lock     = w_match_ok && (r_match == MW'(LOCK_CYCLES - 1));
    // Saturating increment; also used for the DONE-entry pass compare so a
    // mismatch on the final DRAIN cycle is included.
    assign w_err_next = (w_miss && (r_err != '1)) ? r_err + 64'd1 : r_err;

`ifdef BER_TEST_LOCK_TIMEOUT_EN
    localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    logic [TW-1:0] r_sync_cnt;
    logic          r_lock_fail;
    logic          w_timeout;
    assign w_timeout     = (r_sync_cnt == TW'(LOCK_TIMEOUT - 1));
    assign bus.lock_fail = r_lock_fail;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (LOCK_TIMEOUT == 0);
    assign bus.lock_fail    = 1'b0;
`endif

    // Transmit generator runs in every state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr <= 7'h7F;
        end else begin
            r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_chk      <= '0;
            r_match    <= '0;
            r_run      <= '0;
            r_drain    <= '0;
            r_err      <= '0;
            r_inj_base <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_inj_stop <= 1'b1;
`ifdef BER_TEST_LOCK_TIMEOUT_EN
            r_sync_cnt  <= '0;
            r_lock_fail <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_SYNC;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_match <= '0;
`ifdef BER_TEST_LOCK_TIMEOUT_EN
                        r_sync_cnt  <= '0;
                        r_lock_fail <= 1'b0;
`endif
                    end
                end
                S_SYNC: begin
                    r_chk   <= {r_chk[5:0], bus.rx_bit};
                    r_match <= w_match_ok ? r_match + MW'(1) : '0;
`ifdef BER_TEST_LOCK_TIMEOUT_EN
                    r_sync_cnt <= r_sync_cnt + TW'(1);
`endif
                    if (w_lock) begin
                        r_state    <= S_RUN;
                        r_inj_stop <= 1'b0;
                        r_err      <= '0;
                        r_inj_base <= bus.inj_errors;
                        r_run      <= RW'(RUN_CYCLES - 1);
                    end
`ifdef BER_TEST_LOCK_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err       <= '0;
                        r_lock_fail <= 1'b1;
                    end
`endif
                end
                S_RUN: begin
                    r_chk <= {r_chk[5:0], w_pred};
                    r_err <= w_err_next;
                    if (r_run == '0) begin
                        r_state    <= S_DRAIN;
                        r_inj_stop <= 1'b1;
                        r_drain    <= DW'(DRAIN_CYCLES - 1);
                    end else begin
                        r_run <= r_run - RW'(1);
                    end
                end
                S_DRAIN: begin
                    r_chk <= {r_chk[5:0], w_pred};
                    r_err <= w_err_next;
                    if (r_drain == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == (bus.inj_errors - r_inj_base));
                    end else begin
                        r_drain <= r_drain - DW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_bit    = r_lfsr[6];
    assign bus.inj_stop  = r_inj_stop;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
endmodule
